// File: rtl/fft64_in_reorder.sv
`default_nettype none
// ============================================================================
// Module   : fft64_in_reorder
// Purpose  : Streaming input buffer in front of the first radix-8 stage of a
//            64-point FFT. Samples arrive in natural order (0..63), one per
//            cycle, and are written into a ping-pong memory. Each full frame is
//            then emitted as 8 packed vectors; vector r carries the samples
//            r, r+8, ..., r+56, which is the 8-lane input of the FFT-8 stage.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DW         width of each real/imag component (two's complement)
// Ports
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input sample valid
//   in_ready   buffer can accept a sample this cycle (combinational)
//   in_re      sample real part
//   in_im      sample imag part
//   out_valid  output vector valid
//   out_ready  consumer accepts vector
//   out_re     packed real parts, lane k at [DW*k +: DW]
//   out_im     packed imag parts, same lane packing
//   out_last   high on vector 7 of a frame
//   out_grp    group index r of the current vector
// Optional feature (define FFT64_IN_SOF_EN to enable)
//   in_sof     start-of-frame marker, sampled only on accept; realigns the
//              write counter to index 0 of the current write bank
//   sof_err    sticky framing error flag, cleared only by reset
// ============================================================================
module fft64_in_reorder #(
  parameter int DW = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_re,
  input  logic [DW-1:0]   in_im,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [8*DW-1:0] out_re,
  output logic [8*DW-1:0] out_im,
  output logic            out_last,
  output logic [2:0]      out_grp
`ifdef FFT64_IN_SOF_EN
  ,
  input  logic            in_sof,
  output logic            sof_err
`endif
);

  localparam int LANES = 8;
  localparam int AW    = 6;          // address bits within one bank
  localparam int WW    = 2 * DW;     // stored word: {re, im}

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [AW-1:0]       wr_cnt_q,    wr_cnt_d;
  logic                wb_q,        wb_d;
  logic                rb_q,        rb_d;
  logic [2:0]          rd_grp_q,    rd_grp_d;
  logic [1:0]          bank_full_q, bank_full_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q,  out_last_d;
  logic [2:0]          out_grp_q,   out_grp_d;
  logic [8*DW-1:0]     out_re_q,    out_re_d;
  logic [8*DW-1:0]     out_im_q,    out_im_d;

  // Both banks in one array, addressed as {bank, index}. Contents are not
  // reset: a bank is only read after it has been completely written.
  logic [WW-1:0]       mem [2*64];

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic                accept;
  logic                sof_hit;
  logic [AW-1:0]       wr_idx;
  logic                load;
  logic [8*DW-1:0]     rd_re;
  logic [8*DW-1:0]     rd_im;

  assign in_ready = !bank_full_q[wb_q];
  assign accept   = in_valid && in_ready;

`ifdef FFT64_IN_SOF_EN
  logic sof_err_q, sof_err_d;
  assign sof_hit = accept && in_sof;
`else
  assign sof_hit = 1'b0;
`endif

  // A start-of-frame marker overrides the running count and lands at index 0.
  assign wr_idx = sof_hit ? '0 : wr_cnt_q;

  // The output register may be refilled when it is empty or being consumed.
  assign load = bank_full_q[rb_q] && (!out_valid_q || out_ready);

  // --------------------------------------------------------------------------
  // Write port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[{wb_q, wr_idx}] <= {in_re, in_im};
    end
  end

  // --------------------------------------------------------------------------
  // Read lanes: lane k of group r is sample r + 8k, i.e. address {k, r}.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WW-1:0] word;
    assign word                 = mem[{rb_q, 3'(k), rd_grp_q}];
    assign rd_re[DW*k +: DW]    = word[WW-1:DW];
    assign rd_im[DW*k +: DW]    = word[DW-1:0];
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    wb_d        = wb_q;
    rb_d        = rb_q;
    rd_grp_d    = rd_grp_q;
    bank_full_d = bank_full_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_grp_d   = out_grp_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;

    // Write side. Setting a full flag can never collide with clearing one on
    // the read side: set needs the bank empty, clear needs it full.
    if (accept) begin
      wr_cnt_d = wr_idx + 6'd1;
      if (wr_idx == 6'd63) begin
        bank_full_d[wb_q] = 1'b1;
        wb_d              = ~wb_q;
      end
    end

    // Read side. Output fields other than out_valid keep their value when a
    // vector is consumed without a refill.
    if (load) begin
      out_re_d    = rd_re;
      out_im_d    = rd_im;
      out_grp_d   = rd_grp_q;
      out_last_d  = (rd_grp_q == 3'd7);
      out_valid_d = 1'b1;
      rd_grp_d    = rd_grp_q + 3'd1;
      if (rd_grp_q == 3'd7) begin
        bank_full_d[rb_q] = 1'b0;
        rb_d              = ~rb_q;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

`ifdef FFT64_IN_SOF_EN
  // A marker away from index 0, or index 0 without a marker, is a framing
  // error. The flag is sticky.
  always_comb begin
    sof_err_d = sof_err_q;
    if (accept) begin
      if (in_sof && (wr_cnt_q != 6'd0)) begin
        sof_err_d = 1'b1;
      end
      if (!in_sof && (wr_cnt_q == 6'd0)) begin
        sof_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sof_err_q <= 1'b0;
    end else begin
      sof_err_q <= sof_err_d;
    end
  end

  assign sof_err = sof_err_q;
`endif

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q    <= '0;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      rd_grp_q    <= '0;
      bank_full_q <= 2'b00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_grp_q   <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      rd_grp_q    <= rd_grp_d;
      bank_full_q <= bank_full_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_grp_q   <= out_grp_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_grp   = out_grp_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;

endmodule
`default_nettype wire

// File: tb/tb_fft64_in_reorder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fft64_in_reorder
// Purpose  : Self-checking bench for fft64_in_reorder. A frame-level model
//            collects accepted samples into a 64-entry frame and, when the
//            frame completes, queues the 8 expected output vectors
//            (vector r, lane k = sample r + 8k).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft64_in_reorder;

  localparam int DW = 10;
  localparam int VW = 8 * DW;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_re     = '0;
  logic [DW-1:0] in_im     = '0;
  logic          in_ready;
  logic          out_valid;
  logic [VW-1:0] out_re;
  logic [VW-1:0] out_im;
  logic          out_last;
  logic [2:0]    out_grp;
`ifdef FFT64_IN_SOF_EN
  logic          in_sof_v  = 1'b0;
  logic          sof_err;
  logic          m_err     = 1'b0;
  int            pos       = 0;
`endif

  fft64_in_reorder #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (out_last),
    .out_grp   (out_grp)
`ifdef FFT64_IN_SOF_EN
    ,
    .in_sof    (in_sof_v),
    .sof_err   (sof_err)
`endif
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  logic [DW-1:0] m_re [64];
  logic [DW-1:0] m_im [64];
  int            m_cnt = 0;
  logic [VW-1:0] q_re [$];
  logic [VW-1:0] q_im [$];
  logic [2:0]    q_grp [$];
  int            n_vec = 0;
  int            n_valid_cyc = 0;

  task automatic push_frame();
    for (int r = 0; r < 8; r++) begin
      logic [VW-1:0] vr;
      logic [VW-1:0] vi;
      for (int k = 0; k < 8; k++) begin
        vr[DW*k +: DW] = m_re[r + 8*k];
        vi[DW*k +: DW] = m_im[r + 8*k];
      end
      q_re.push_back(vr);
      q_im.push_back(vi);
      q_grp.push_back(3'(r));
    end
  endtask

  task automatic model_reset();
    q_re.delete();
    q_im.delete();
    q_grp.delete();
    m_cnt = 0;
`ifdef FFT64_IN_SOF_EN
    m_err = 1'b0;
    pos   = 0;
`endif
  endtask

  // Monitor: inputs change just after posedge, so at negedge they show the
  // handshakes that will complete at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
`ifdef FFT64_IN_SOF_EN
      chk_eq("sof_err", VW'(sof_err), VW'(m_err));
`endif
      if (out_valid) begin
        n_valid_cyc++;
        if (q_re.size() == 0) begin
          chk_eq("spurious_vec", 1, 0);
        end else begin
          chk_eq("out_re",   out_re,       q_re[0]);
          chk_eq("out_im",   out_im,       q_im[0]);
          chk_eq("out_grp",  VW'(out_grp), VW'(q_grp[0]));
          chk_eq("out_last", VW'(out_last), VW'(q_grp[0] == 3'd7));
          if (out_ready) begin
            void'(q_re.pop_front());
            void'(q_im.pop_front());
            void'(q_grp.pop_front());
            n_vec++;
          end
        end
      end
      if (in_valid && in_ready) begin
`ifdef FFT64_IN_SOF_EN
        if (in_sof_v) begin
          if (m_cnt != 0) m_err = 1'b1;
          m_cnt = 0;
        end else if (m_cnt == 0) begin
          m_err = 1'b1;
        end
`endif
        m_re[m_cnt] = in_re;
        m_im[m_cnt] = in_im;
        m_cnt++;
        if (m_cnt == 64) begin
          push_frame();
          m_cnt = 0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (all input changes happen 1 ns after a rising edge)
  // --------------------------------------------------------------------------
  logic expect_ready = 1'b0;
  logic rand_ready   = 1'b0;
  logic gap_en       = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic drive(input logic [DW-1:0] re, input logic [DW-1:0] im);
    int  t;
    logic acc;
    t   = 0;
    acc = 1'b0;
    if (gap_en) idle($urandom_range(0, 2));
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
`ifdef FFT64_IN_SOF_EN
    in_sof_v = (pos == 0);
`endif
    while (!acc && t < 500) begin
      @(negedge clk);
      if (expect_ready) chk_eq("in_ready_hi", VW'(in_ready), 1);
      acc = in_ready;
      step();
      t++;
    end
    if (!acc) chk_eq("accept_timeout", 0, 1);
`ifdef FFT64_IN_SOF_EN
    pos = (pos + 1) % 64;
`endif
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while (q_re.size() != 0 && t < 300) begin
      idle(1);
      t++;
    end
    chk_eq("drain_done", VW'(q_re.size()), 0);
    idle(2);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int v0;
    int t;
    logic got;

    // Reset state
    #12;
    chk_eq("rst_out_valid", VW'(out_valid), 0);
    chk_eq("rst_out_last",  VW'(out_last),  0);
    chk_eq("rst_out_grp",   VW'(out_grp),   0);
    chk_eq("rst_out_re",    out_re,         0);
    chk_eq("rst_out_im",    out_im,         0);
    chk_eq("rst_in_ready",  VW'(in_ready),  1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    step();

    // Single frame, re=n im=-n, with latency and valid-cycle count
    out_ready   = 1'b1;
    v0          = n_vec;
    n_valid_cyc = 0;
    for (int n = 0; n < 64; n++) drive(DW'(n), DW'(-n));
    @(negedge clk);
    chk_eq("lat_not_yet", VW'(out_valid), 0);
    @(negedge clk);
    chk_eq("lat_valid",   VW'(out_valid), 1);
    chk_eq("lat_grp0",    VW'(out_grp),   0);
    drain();
    chk_eq("single_nvec",  VW'(n_vec - v0), 8);
    chk_eq("single_valid", VW'(n_valid_cyc), 8);

    // Three back-to-back frames, in_ready must never drop
    expect_ready = 1'b1;
    v0 = n_vec;
    for (int n = 0; n < 192; n++) drive(DW'(n), DW'($urandom));
    expect_ready = 1'b0;
    drain();
    chk_eq("b2b_nvec", VW'(n_vec - v0), 24);

    // Backpressure: both banks fill, in_ready falls after sample 127
    out_ready    = 1'b0;
    expect_ready = 1'b1;
    v0 = n_vec;
    for (int n = 0; n < 128; n++) drive(DW'($urandom), DW'($urandom));
    expect_ready = 1'b0;
    in_valid = 1'b1;
    in_re    = DW'($urandom);
    in_im    = DW'($urandom);
`ifdef FFT64_IN_SOF_EN
    in_sof_v = (pos == 0);
`endif
    for (int c = 0; c < 72; c++) begin
      @(negedge clk);
      if (c == 0 || c == 71) begin
        chk_eq("bp_in_ready_lo", VW'(in_ready), 0);
        chk_eq("bp_grp_hold",    VW'(out_grp),  0);
      end
      step();
    end
    out_ready = 1'b1;
    got = 1'b0;
    t   = 0;
    while (!got && t < 12) begin
      @(negedge clk);
      got = in_ready;
      if (!got) step();
      t++;
    end
    chk_eq("bp_in_ready_back", VW'(got), 1);
    drive(in_re, in_im);
    for (int n = 1; n < 64; n++) drive(DW'($urandom), DW'($urandom));
    drain();
    chk_eq("bp_nvec", VW'(n_vec - v0), 24);

    // Extreme values are forwarded untouched
    for (int n = 0; n < 64; n++) drive(10'h1FF, 10'h200);
    @(negedge clk);
    @(negedge clk);
    chk_eq("ext_re", out_re, {8{10'h1FF}});
    chk_eq("ext_im", out_im, {8{10'h200}});
    drain();

    // Randomized traffic with random gaps and backpressure
    gap_en     = 1'b1;
    rand_ready = 1'b1;
    v0 = n_vec;
    for (int n = 0; n < 4 * 64; n++) drive(DW'($urandom), DW'($urandom));
    rand_ready = 1'b0;
    gap_en     = 1'b0;
    drain();
    chk_eq("rand_nvec", VW'(n_vec - v0), 32);

    // Reset mid-frame with a vector pending
    out_ready = 1'b0;
    for (int n = 0; n < 64 + 40; n++) drive(DW'($urandom), DW'($urandom));
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_eq("mid_rst_valid", VW'(out_valid), 0);
    chk_eq("mid_rst_ready", VW'(in_ready),  1);
    idle(2);
    #1;
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    v0 = n_vec;
    for (int n = 0; n < 64; n++) drive(DW'(n + 300), DW'($urandom));
    drain();
    chk_eq("post_rst_nvec", VW'(n_vec - v0), 8);

`ifdef FFT64_IN_SOF_EN
    // Marker at sample 20 abandons the partial frame
    chk_eq("sof_err_clean", VW'(sof_err), 0);
    v0 = n_vec;
    for (int n = 0; n < 20; n++) drive(DW'($urandom), DW'($urandom));
    pos = 0;
    for (int n = 0; n < 64; n++) drive(DW'(n), DW'($urandom));
    drain();
    chk_eq("sof_err_set",  VW'(sof_err), 1);
    chk_eq("sof_nvec",     VW'(n_vec - v0), 8);
`endif

    chk_eq("final_queue", VW'(q_re.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0t exp=finish", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/fft64_in_reorder.md
Name: fft64_in_reorder

Overview:
- Streaming input buffer that sits directly upstream of the combinational 8-point FFT (first radix-8 stage of the 64-point FFT).
- Accepts one complex sample per cycle in natural order (index 0..63) over a valid/ready handshake.
- Stores each 64-sample frame in a ping-pong memory.
- Emits 8 packed vectors per frame, each one the 8-lane input of the FFT-8 stage: vector r carries samples r, r+8, …, r+56.

Parameters:
DW, 10, width of each real/imag component (two's complement); the FFT-8 stage requires 10

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  buffer can accept a sample this cycle
in_re  in  DW  sample real part
in_im  in  DW  sample imag part
out_valid  out  1  output vector valid
out_ready  in  1  consumer accepts vector
out_re  out  8*DW  packed real parts; lane k at bits [DW*k+DW-1 : DW*k]
out_im  out  8*DW  packed imag parts, same lane packing
out_last  out  1  high on vector 7 of a frame
out_grp  out  3  group index r of current vector

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: out_valid=0, out_last=0, out_grp=0, out_re=0, out_im=0. Internal state clears to wr_cnt=0, wb=0, rb=0, rd_grp=0, bank_full=2'b00. Memory contents are not reset. in_ready is combinational and is therefore 1 right after reset.
- Storage: two banks, each 64 entries × 2·DW bits. wb selects the write bank; rb selects the read bank.
- in_ready = !bank_full[wb]. A sample is accepted when in_valid && in_ready.
- On accept: mem[wb][wr_cnt] <= {in_re, in_im}; wr_cnt increments by 1 and wraps 63→0.
  - If wr_cnt==63, then bank_full[wb] <= 1 and wb toggles.
- Read load condition: load = bank_full[rb] && (!out_valid || out_ready).
- On load:
  - Lane k of out_re/out_im <= mem[rb][rd_grp + 8k], for k=0..7.
  - out_grp <= rd_grp; out_last <= (rd_grp==7); out_valid <= 1; rd_grp increments.
  - If rd_grp==7: bank_full[rb] <= 0, rb toggles, rd_grp wraps to 0.
- Without a load, out_valid && out_ready clears out_valid at the edge.
- Output registers hold their value while out_valid && !out_ready (no change under backpressure).
- Latency: the 64th sample of a frame is accepted at edge E; the first vector of that frame is valid after edge E+1.
- Throughput: with out_ready=1, a frame drains in 8 cycles. in_ready stays 1 continuously, giving a sustained rate of 1 sample/cycle with no bubbles.
- Simultaneous events:
  - Bank set and bank clear in the same cycle always hit different banks: set needs the bank not full, clear needs it full.
  - A bank freed at edge E is writable from cycle E+1 (in_ready rises after E).
- Both banks full: in_ready=0 until vector 7 of bank rb is loaded.
- Data is stored and forwarded bit-exact; no arithmetic, no width change.
- Reset mid-frame: partial frames and pending vectors are discarded. Reset takes effect immediately (asynchronous); the first sample accepted after release is index 0 of bank 0.

Optional Feature:
FFT64_IN_SOF_EN
- Enabled:
  - Adds input port in_sof (1 bit), sampled only on accept. An accept with in_sof=1 forces that sample to index 0 of the current bank wb; any partial frame in wb is abandoned, and wr_cnt continues from 1.
  - Adds output port sof_err (1 bit, reset 0), sticky until reset. It is set when in_sof=1 arrives with wr_cnt≠0, or when wr_cnt==0 is accepted with in_sof=0.
- Disabled: neither port exists; framing is purely by count.

Test Plan:
- Single frame, out_ready=1: feed re=n, im=-n for n=0..63 → 1 cycle after the last accept, vector r (r=0..7) has lane k re=r+8k and im=-(r+8k); out_last only on r=7; exactly 8 valid cycles.
- Back-to-back frames with in_valid=1 continuous: 3 frames of 192 samples → in_ready never drops; 24 vectors in order; frame 1, vector 2, lane 5 re=64+42=106 (10-bit two's complement wraps at 512, so values ≥512 read negative).
- Backpressure: out_ready=0 for 200 cycles while streaming → in_ready falls after sample 127; out_re/out_im/out_grp hold constant; on out_ready=1, 16 vectors emerge correct and in_ready returns 1 after vector 7 of frame 0.
- Extreme values: in_re=+511 and in_im=-512 for all samples → every lane shows 0x1FF and 0x200 unmodified.
- Reset mid-frame: assert rst_n=0 after 40 samples → out_valid=0 and in_ready=1 immediately; a fresh 64-sample frame outputs correctly with out_grp starting at 0.
- FFT64_IN_SOF_EN: in_sof at sample 20 of a frame → sof_err=1; the next 63 samples complete the frame with the in_sof sample at index 0.
